// File: rtl/ula_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ula_pkg                                                           |
// | Brief  : Op codes, FSM encoding and sizing helpers for the serial ALU.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package ula_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_e;

   function automatic int calc_nslice(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int calc_cnt_w(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ula_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ula_slice                                                         |
// | Brief  : Combinational DIGIT-wide ALU slice with carry chain taps.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ula_slice
   import ula_pkg::*;
#(
   parameter int DIGIT = 4
)
(
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic [2:0]       i_op,
   input  logic             i_carry,
   output logic [DIGIT-1:0] o_res,
   output logic             o_carry,
   output logic             o_carry_msb
);

   logic [DIGIT-1:0] w_b;
   logic [DIGIT:0]   w_c;

   // Explicit ripple so the carry into the top bit is available for overflow.
   always_comb begin
      w_b    = (i_op == OP_SUB) ? ~i_b : i_b;
      w_c    = '0;
      w_c[0] = i_carry;
      for (int i = 0; i < DIGIT; i++) begin
         w_c[i+1] = (i_a[i] & w_b[i]) | (i_a[i] & w_c[i]) | (w_b[i] & w_c[i]);
      end
   end

   always_comb begin
      o_res = '0;
      case (i_op)
         OP_ADD, OP_SUB: o_res = i_a ^ w_b ^ w_c[DIGIT-1:0];
         OP_AND:         o_res = i_a & i_b;
         OP_OR:          o_res = i_a | i_b;
         OP_XOR:         o_res = i_a ^ i_b;
         default:        o_res = '0;
      endcase
   end

   assign o_carry     = w_c[DIGIT];
   assign o_carry_msb = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/ula_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ula_serial                                                        |
// | Brief  : Digit-serial ALU (ADD/SUB/AND/OR/XOR) with valid/ready handshake. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module ula_serial
   import ula_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = calc_nslice(WIDTH, DIGIT);
   localparam int CNT_W  = calc_cnt_w(NSLICE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   generate
      if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
         $error("ula_serial: WIDTH must be a non-zero multiple of DIGIT");
      end
   endgenerate

   state_e           r_state;
   state_e           w_state_nxt;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic [WIDTH-1:0] r_result;
   logic             r_c_out;
   logic             r_ovf;
   logic             r_zero;
   logic [DIGIT-1:0] w_a_sl;
   logic [DIGIT-1:0] w_b_sl;
   logic [DIGIT-1:0] w_sl_res;
   logic             w_sl_carry;
   logic             w_sl_cmsb;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_arith;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == LAST_CNT) begin
               w_last      = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_a_sl = '0;
      w_b_sl = '0;
      for (int s = 0; s < NSLICE; s++) begin
         if (r_cnt == CNT_W'(s)) begin
            w_a_sl = r_a[s*DIGIT +: DIGIT];
            w_b_sl = r_b[s*DIGIT +: DIGIT];
         end
      end
   end

   ula_slice #(
      .DIGIT       (DIGIT)
   ) u_slice (
      .i_a         (w_a_sl),
      .i_b         (w_b_sl),
      .i_op        (r_op),
      .i_carry     (r_carry),
      .o_res       (w_sl_res),
      .o_carry     (w_sl_carry),
      .o_carry_msb (w_sl_cmsb)
   );

   // Result with the current slice merged in; the zero flag looks at this on the final slice.
   always_comb begin
      w_res_nxt = r_result;
      for (int s = 0; s < NSLICE; s++) begin
         if (r_cnt == CNT_W'(s)) begin
            w_res_nxt[s*DIGIT +: DIGIT] = w_sl_res;
         end
      end
   end

   assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_ADD;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_c_out  <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_op    <= op;
         r_cnt   <= '0;
         // Subtraction runs as a + ~b + 1 - borrow, so the borrow-in is inverted.
         r_carry <= (op == OP_SUB) ? ~c_in : c_in;
      end else if (r_state == S_BUSY) begin
         r_result <= w_res_nxt;
         r_carry  <= w_sl_carry;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_c_out <= w_arith & ((r_op == OP_SUB) ? ~w_sl_carry : w_sl_carry);
            r_ovf   <= w_arith & (w_sl_cmsb ^ w_sl_carry);
            r_zero  <= ~|w_res_nxt;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign c_out     = r_c_out;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_ula_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ula_serial                                                     |
// | Brief  : Scoreboard bench for ula_serial at W16/D4 and W2/D1.              |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ula_serial;
   import ula_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf, zero;
   logic [2:0]  op;
   logic [15:0] a, b, result;
   logic        s_in_valid, s_in_ready, s_c_in, s_out_valid, s_out_ready, s_c_out, s_ovf, s_zero;
   logic [2:0]  s_op;
   logic [1:0]  s_a, s_b, s_result;

   ula_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .c_out(c_out), .ovf(ovf), .zero(zero)
   );

   ula_serial #(.WIDTH(2), .DIGIT(1)) u_dut_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
      .a(s_a), .b(s_b), .c_in(s_c_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .result(s_result), .c_out(s_c_out), .ovf(s_ovf), .zero(s_zero)
   );

   typedef struct { logic [2:0] op; logic [15:0] a; logic [15:0] b;
                    logic [15:0] res; logic c; logic v; logic z; } exp_t;
   typedef struct { logic [1:0] a; logic [1:0] b; logic ci;
                    logic [1:0] res; logic c; logic v; logic z; } sexp_t;
   typedef struct { string name; bit tout; logic ir; logic ov; bit chk;
                    logic [15:0] res; logic c; logic v; logic z; } st_t;

   exp_t  exp_q[$];
   sexp_t sexp_q[$];
   st_t   st_q[$];
   int    acc_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push_st(input string name, input bit tout, input logic ir,
                                   input logic ov, input bit chk, input logic [15:0] res,
                                   input logic c, input logic v, input logic z);
      st_t s;
      s.name = name; s.tout = tout; s.ir = ir; s.ov = ov; s.chk = chk;
      s.res = res; s.c = c; s.v = v; s.z = z;
      st_q.push_back(s);
   endfunction

   // Monitor: the only process that steps the comparison counters.
   st_t         m_s;
   exp_t        m_e;
   sexp_t       m_se;
   int          m_lat;
   logic        prev_ov = 1'b0;
   logic        prev_or = 1'b0;
   logic [18:0] prev_out = '0;

   always @(negedge clk) begin
      #1;
      while (st_q.size() > 0) begin
         m_s = st_q.pop_front();
         n_cmp++;
         if (m_s.tout) begin
            n_bad++;
            $display("FAIL %s: wait bound expired", m_s.name);
         end else if (in_ready !== m_s.ir || out_valid !== m_s.ov ||
                      (m_s.chk && {result, c_out, ovf, zero} !== {m_s.res, m_s.c, m_s.v, m_s.z})) begin
            n_bad++;
            $display("FAIL %s: got ir=%b ov=%b res=%h c=%b v=%b z=%b, want ir=%b ov=%b res=%h c=%b v=%b z=%b",
                     m_s.name, in_ready, out_valid, result, c_out, ovf, zero,
                     m_s.ir, m_s.ov, m_s.res, m_s.c, m_s.v, m_s.z);
         end
      end
      if (rst) begin
         prev_ov = 1'b0;
         prev_or = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            n_cmp++;
            if (acc_q.size() == 0) begin
               n_bad++;
               $display("FAIL latency: out_valid=1 with no accepted command, want none");
            end else begin
               m_lat = cyc - acc_q.pop_front();
               if (m_lat != 4) begin
                  n_bad++;
                  $display("FAIL latency: got %0d cycles, want 4", m_lat);
               end
            end
         end
         if (out_valid && prev_ov && !prev_or) begin
            n_cmp++;
            if ({result, c_out, ovf, zero} !== prev_out) begin
               n_bad++;
               $display("FAIL hold: got %h, want %h", {result, c_out, ovf, zero}, prev_out);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL result: got unexpected res=%h, want no output", result);
            end else begin
               m_e = exp_q.pop_front();
               if ({result, c_out, ovf, zero} !== {m_e.res, m_e.c, m_e.v, m_e.z}) begin
                  n_bad++;
                  $display("FAIL result op=%0d a=%h b=%h: got res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b",
                           m_e.op, m_e.a, m_e.b, result, c_out, ovf, zero,
                           m_e.res, m_e.c, m_e.v, m_e.z);
               end
            end
         end
         if (s_out_valid && s_out_ready) begin
            n_cmp++;
            if (sexp_q.size() == 0) begin
               n_bad++;
               $display("FAIL small: got unexpected res=%h, want no output", s_result);
            end else begin
               m_se = sexp_q.pop_front();
               if ({s_result, s_c_out, s_ovf, s_zero} !== {m_se.res, m_se.c, m_se.v, m_se.z}) begin
                  n_bad++;
                  $display("FAIL small a=%h b=%h ci=%b: got res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b",
                           m_se.a, m_se.b, m_se.ci, s_result, s_c_out, s_ovf, s_zero,
                           m_se.res, m_se.c, m_se.v, m_se.z);
               end
            end
         end
         prev_ov  = out_valid;
         prev_or  = out_ready;
         prev_out = {result, c_out, ovf, zero};
      end
   end

   task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input logic [15:0] er, input logic ec,
                        input logic ev, input logic ez, input bit push);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         push_st("issue_wait", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
         return;
      end
      op = o; a = x; b = y; c_in = ci; in_valid = 1'b1;
      if (push) begin
         e.op = o; e.a = x; e.b = y; e.res = er; e.c = ec; e.v = ev; e.z = ez;
         exp_q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      c_in = ~ci;
      if (push) acc_q.push_back(cyc);
   endtask

   task automatic issue_s(input logic [1:0] x, input logic [1:0] y, input logic ci,
                          input logic [1:0] er, input logic ec, input logic ev, input logic ez);
      sexp_t e;
      int    n = 0;
      @(negedge clk);
      while (!s_in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_in_ready) begin
         push_st("issue_s_wait", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
         return;
      end
      s_op = OP_ADD; s_a = x; s_b = y; s_c_in = ci; s_in_valid = 1'b1;
      e.a = x; e.b = y; e.ci = ci; e.res = er; e.c = ec; e.v = ev; e.z = ez;
      sexp_q.push_back(e);
      @(negedge clk);
      s_in_valid = 1'b0;
      s_a = ~x;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() > 0 || sexp_q.size() > 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0 || sexp_q.size() > 0)
         push_st("drain", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [1:0] x, y;
      logic       ci;
      logic [2:0] sum;
      int         sx, sy, ss, n;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = OP_ADD;
      a = '0; b = '0; c_in = 1'b0;
      s_in_valid = 1'b0; s_out_ready = 1'b1; s_op = OP_ADD; s_a = '0; s_b = '0; s_c_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      push_st("reset", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      issue(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
      issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
      issue(OP_ADD, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
      issue(OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1);
      issue(OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
      issue(OP_SUB, 16'h0010, 16'h0001, 1'b1, 16'h000E, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_XOR, 16'hA5A5, 16'h0FF0, 1'b1, 16'hAA55, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_AND, 16'hA5A5, 16'h0FF0, 1'b0, 16'h05A0, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_OR,  16'hA5A5, 16'h0FF0, 1'b0, 16'hAFF5, 1'b0, 1'b0, 1'b0, 1'b1);
      issue(OP_AND, 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
      issue(3'b111, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);

      // Backpressure: result held for 5 cycles, a stray command is ignored.
      wait_drain();
      out_ready = 1'b0;
      issue(OP_ADD, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid)
         push_st("bp_wait", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         push_st("bp_hold", 1'b0, 1'b0, 1'b1, 1'b1, 16'h2346, 1'b0, 1'b0, 1'b0);
         in_valid = (k == 1);
         op = OP_XOR; a = 16'hFFFF; b = 16'h0001;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      push_st("bp_release", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

      // Reset in the second BUSY cycle abandons the operation.
      wait_drain();
      issue(OP_SUB, 16'h0009, 16'h0009, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      push_st("rst_busy", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      issue(OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1);

      // W2/D1 exhaustive ADD against a signed/unsigned arithmetic model.
      for (int i = 0; i < 64; i++) begin
         x   = i[5:4];
         y   = i[3:2];
         ci  = i[0];
         sum = {1'b0, x} + {1'b0, y} + {2'b00, ci};
         sx  = x[1] ? int'(x) - 4 : int'(x);
         sy  = y[1] ? int'(y) - 4 : int'(y);
         ss  = sx + sy + int'(ci);
         issue_s(x, y, ci, sum[1:0], sum[2], (ss > 1) || (ss < -2), sum[1:0] == 2'b00);
      end

      wait_drain();
      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
